dmem_arbiter: RTL and testbench

//  Shares the single data-memory port between two requesters: port 0 = CPU MEM stage,

---
 rtl/dmem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single data-memory port between two requesters:
//     port 0 : CPU MEM stage
//     port 1 : loader / debug DMA
//   Latches one request at a time. It drives the DMem interface from the
//   latched request and returns a registered response. Misaligned half-word
//   and word accesses never reach memory and are flagged with mNErr.
//
//   Transaction timing: IDLE -> ACCESS -> RESP -> IDLE, 3 cycles minimum.
//   A locked owner can chain RESP -> ACCESS, which gives one access every
//   2 cycles.
//
// Configuration macro:
//   DMEM_ARB_RR_EN  defined   : round-robin. On simultaneous requests the port
//                               that was not granted last wins.
//                   undefined : fixed priority, port 0 wins.
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   mNReq/We/Lock/Addr/Size/WData request side, N = 0,1
//   mNGnt                         1-cycle pulse: request latched
//   mNAck, mNErr                  1-cycle pulse: done / misaligned
//   mNRData                       load data, valid with mNAck (shared register)
//   memAddr/WriteEnable/UnitSize/WriteData -> DMem
//   memReadData                   <- DMem (combinational read)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0Req,
    input  logic              m0We,
    input  logic              m0Lock,
    input  logic [ADDR_W-1:0] m0Addr,
    input  logic [2:0]        m0Size,
    input  logic [DATA_W-1:0] m0WData,
    output logic              m0Gnt,
    output logic              m0Ack,
    output logic              m0Err,
    output logic [DATA_W-1:0] m0RData,
    input  logic              m1Req,
    input  logic              m1We,
    input  logic              m1Lock,
    input  logic [ADDR_W-1:0] m1Addr,
    input  logic [2:0]        m1Size,
    input  logic [DATA_W-1:0] m1WData,
    output logic              m1Gnt,
    output logic              m1Ack,
    output logic              m1Err,
    output logic [DATA_W-1:0] m1RData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWriteEnable,
    output logic [2:0]        memUnitSize,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              misaligned;
    logic              win;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_size;
    logic [DATA_W-1:0] sel_wdata;
    logic              owner_req;
    logic              owner_lock;

    // Alignment check on the latched request. Bytes are never misaligned.
    // Undefined sizes follow the word rule.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr_q[0];
            default:        misaligned = (addr_q[1:0] != 2'b00);
        endcase
    end

    // IDLE winner. The result is only used when at least one request is high.
    always_comb begin
        win = 1'b0;
`ifdef DMEM_ARB_RR_EN
        if (m0Req && m1Req)
            win = ~last_grant;
        else
            win = m1Req;
`else
        win = ~m0Req;
`endif
    end

    // One latch mux serves both entry points: the IDLE winner, or the owner
    // chaining a locked follow-on request from RESP.
    always_comb begin
        sel       = (state == RESP) ? owner : win;
        sel_we    = sel ? m1We    : m0We;
        sel_addr  = sel ? m1Addr  : m0Addr;
        sel_size  = sel ? m1Size  : m0Size;
        sel_wdata = sel ? m1WData : m0WData;
        owner_req  = owner ? m1Req  : m0Req;
        owner_lock = owner ? m1Lock : m0Lock;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            m0Gnt      <= 1'b0;
            m1Gnt      <= 1'b0;
            m0Ack      <= 1'b0;
            m1Ack      <= 1'b0;
            m0Err      <= 1'b0;
            m1Err      <= 1'b0;
        end else begin
            m0Gnt <= 1'b0;
            m1Gnt <= 1'b0;
            m0Ack <= 1'b0;
            m1Ack <= 1'b0;
            m0Err <= 1'b0;
            m1Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0Req || m1Req) begin
                        owner   <= sel;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        size_q  <= sel_size;
                        wdata_q <= sel_wdata;
                        m0Gnt   <= ~sel;
                        m1Gnt   <= sel;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The DMem write lands on this same edge. Stores and
                    // blocked accesses return zero data.
                    rdata_q    <= (we_q || misaligned) ? '0 : memReadData;
                    last_grant <= owner;
                    m0Ack      <= ~owner;
                    m1Ack      <= owner;
                    m0Err      <= ~owner & misaligned;
                    m1Err      <= owner & misaligned;
                    state      <= RESP;
                end
                RESP: begin
                    // Lock only extends ownership while the owner actually requests.
                    if (owner_lock && owner_req) begin
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        size_q  <= sel_size;
                        wdata_q <= sel_wdata;
                        m0Gnt   <= ~owner;
                        m1Gnt   <= owner;
                        state   <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable is decoded from state, so an asynchronous reset in ACCESS
    // drops it at once.
    assign memWriteEnable = (state == ACCESS) && we_q && !misaligned;
    assign memAddr        = addr_q;
    assign memUnitSize    = size_q;
    assign memWriteData   = wdata_q;
    assign m0RData        = rdata_q;
    assign m1RData        = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0Req, m0We, m0Lock, m1Req, m1We, m1Lock;
    logic [31:0] m0Addr, m0WData, m1Addr, m1WData;
    logic [2:0]  m0Size, m1Size;
    logic        m0Gnt, m0Ack, m0Err, m1Gnt, m1Ack, m1Err;
    logic [31:0] m0RData, m1RData;
    logic [31:0] memAddr, memWriteData, memReadData;
    logic        memWriteEnable;
    logic [2:0]  memUnitSize;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0Req(m0Req), .m0We(m0We), .m0Lock(m0Lock), .m0Addr(m0Addr),
        .m0Size(m0Size), .m0WData(m0WData), .m0Gnt(m0Gnt), .m0Ack(m0Ack),
        .m0Err(m0Err), .m0RData(m0RData),
        .m1Req(m1Req), .m1We(m1We), .m1Lock(m1Lock), .m1Addr(m1Addr),
        .m1Size(m1Size), .m1WData(m1WData), .m1Gnt(m1Gnt), .m1Ack(m1Ack),
        .m1Err(m1Err), .m1RData(m1RData),
        .memAddr(memAddr), .memWriteEnable(memWriteEnable),
        .memUnitSize(memUnitSize), .memWriteData(memWriteData),
        .memReadData(memReadData)
    );

    // Little-endian byte memory behaving like DMem: combinational read,
    // sign/zero extension by funct3, and a write on the rising edge.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ra;

    always_comb begin
        ra = memAddr[7:0];
        case (memUnitSize)
            3'b000:  memReadData = {{24{mem[ra][7]}}, mem[ra]};
            3'b001:  memReadData = {{16{mem[ra+8'd1][7]}}, mem[ra+8'd1], mem[ra]};
            3'b100:  memReadData = {24'h0, mem[ra]};
            3'b101:  memReadData = {16'h0, mem[ra+8'd1], mem[ra]};
            default: memReadData = {mem[ra+8'd3], mem[ra+8'd2], mem[ra+8'd1], mem[ra]};
        endcase
    end

    always @(posedge clk) begin
        if (memWriteEnable) begin
            case (memUnitSize)
                3'b000, 3'b100: mem[memAddr[7:0]] <= memWriteData[7:0];
                3'b001, 3'b101: begin
                    mem[memAddr[7:0]]       <= memWriteData[7:0];
                    mem[memAddr[7:0]+8'd1]  <= memWriteData[15:8];
                end
                default: begin
                    mem[memAddr[7:0]]       <= memWriteData[7:0];
                    mem[memAddr[7:0]+8'd1]  <= memWriteData[15:8];
                    mem[memAddr[7:0]+8'd2]  <= memWriteData[23:16];
                    mem[memAddr[7:0]+8'd3]  <= memWriteData[31:24];
                end
            endcase
        end
    end

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endfunction

    typedef struct {
        logic        port;
        logic        we;
        logic        lock;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic gnt_of(input logic p);
        return p ? m1Gnt : m0Gnt;
    endfunction

    function automatic logic ack_of(input logic p);
        return p ? m1Ack : m0Ack;
    endfunction

    task automatic drive(input logic p, input logic req, input logic we, input logic lock,
                         input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        if (!p) begin
            m0Req = req; m0We = we; m0Lock = lock; m0Size = size; m0Addr = addr; m0WData = wdata;
        end else begin
            m1Req = req; m1We = we; m1Lock = lock; m1Size = size; m1Addr = addr; m1WData = wdata;
        end
    endtask

    task automatic push_exp(input logic p, input logic [31:0] rd, input logic e);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        if (p) sb1.push_back(x);
        else   sb0.push_back(x);
    endtask

    // Called at a sample point where port p's ack is expected.
    task automatic pop_check(input logic p, input string tag);
        exp_t x;
        check({tag, "_ack"}, 32'(ack_of(p)), 32'd1);
        check({tag, "_other_ack"}, 32'(ack_of(~p)), 32'd0);
        if ((p ? sb1.size() : sb0.size()) == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = p ? sb1.pop_front() : sb0.pop_front();
            check({tag, "_rdata"}, p ? m1RData : m0RData, x.rdata);
            check({tag, "_err"}, 32'(p ? m1Err : m0Err), 32'(x.err));
        end
    endtask

    // Single transaction from IDLE. Entry and exit are on a falling edge, with
    // the DUT in IDLE.
    task automatic run_txn(input vec_t v);
        int n;
        push_exp(v.port, v.exp_rd, v.exp_err);
        drive(v.port, 1'b1, v.we, v.lock, v.size, v.addr, v.wdata);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (gnt_of(v.port)) break;
        end
        check("gnt_latency", 32'(n), 32'd1);
        check("other_gnt", 32'(gnt_of(~v.port)), 32'd0);
        check("mem_we", 32'(memWriteEnable), 32'(v.we & ~v.exp_err));
        check("mem_addr", memAddr, v.addr);
        if (v.port) m1Req = 1'b0;
        else        m0Req = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (ack_of(v.port)) break;
        end
        check("ack_latency", 32'(n), 32'd1);
        check("mem_we_resp", 32'(memWriteEnable), 32'd0);
        pop_check(v.port, "txn");
        drive(v.port, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic first;
        int   n;

        //            port  we    lock  size    addr        wdata          exp_rd         err
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h80010000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008001, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h11, 32'h0000AAAA, 32'h00000000, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h80010000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h12, 32'h0,        32'h00000000, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h11, 32'h00000055, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        32'h80015500, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 3'b001, 32'h16, 32'h00001234, 32'h00000000, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h14, 32'h0,        32'h12340000, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 3'b011, 32'h14, 32'h0,        32'h12340000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 3'b111, 32'h15, 32'h0,        32'h00000000, 1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_gnt", {30'h0, m1Gnt, m0Gnt}, 32'h0);
        check("rst_ack_err", {28'h0, m1Ack, m0Ack, m1Err, m0Err}, 32'h0);
        check("rst_rdata", m0RData | m1RData, 32'h0);
        check("rst_mem_we", 32'(memWriteEnable), 32'd0);
        check("rst_mem_addr", memAddr, 32'h0);
        check("rst_mem_size_wdata", {29'h0, memUnitSize} | memWriteData, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single-port transactions: sizes, extension, misalignment, lock without req
        for (int i = 0; i < NV; i++) run_txn(vecs[i]);
        check("mem_word_0x10", mem_word(8'h10), 32'h80015500);

        // Simultaneous requests from IDLE. The previous grant went to port 0.
`ifdef DMEM_ARB_RR_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        push_exp(first, first ? 32'h12340000 : 32'h80015500, 1'b0);
        push_exp(~first, first ? 32'h80015500 : 32'h12340000, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h14, 32'h0);
        @(negedge clk);
        check("arb_first_gnt", 32'(gnt_of(first)), 32'd1);
        check("arb_second_gnt", 32'(gnt_of(~first)), 32'd0);
        if (first) m1Req = 1'b0;
        else       m0Req = 1'b0;
        @(negedge clk);
        pop_check(first, "arb_first");
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (gnt_of(~first)) break;
        end
        check("arb_gnt_gap", 32'(n), 32'd3);
        if (first) m0Req = 1'b0;
        else       m1Req = 1'b0;
        @(negedge clk);
        pop_check(~first, "arb_second");
        @(negedge clk);

        // Locked burst on port 1 while port 0 waits
        push_exp(1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h20, 32'h11111111);
        @(negedge clk);
        check("lock_gnt1", 32'(m1Gnt), 32'd1);
        check("lock_addr1", memAddr, 32'h20);
        check("lock_we1", 32'(memWriteEnable), 32'd1);
        push_exp(1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h24, 32'h22222222);
        push_exp(1'b0, 32'h22222222, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h24, 32'h0);
        @(negedge clk);
        pop_check(1'b1, "lock_resp1");
        check("lock_m0_wait1", 32'(m0Gnt), 32'd0);
        @(negedge clk);
        check("lock_gnt2", 32'(m1Gnt), 32'd1);
        check("lock_m0_wait2", 32'(m0Gnt), 32'd0);
        check("lock_addr2", memAddr, 32'h24);
        push_exp(1'b1, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h28, 32'h33333333);
        @(negedge clk);
        pop_check(1'b1, "lock_resp2");
        @(negedge clk);
        check("lock_gnt3", 32'(m1Gnt), 32'd1);
        check("lock_m0_wait3", 32'(m0Gnt), 32'd0);
        check("lock_addr3", memAddr, 32'h28);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        pop_check(1'b1, "lock_resp3");
        check("lock_m0_wait4", 32'(m0Gnt), 32'd0);
        @(negedge clk);
        check("lock_m0_wait5", 32'(m0Gnt) | 32'(m1Gnt), 32'd0);
        @(negedge clk);
        check("lock_m0_gnt", 32'(m0Gnt), 32'd1);
        m0Req = 1'b0;
        @(negedge clk);
        pop_check(1'b0, "lock_m0_resp");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        run_txn('{1'b0, 1'b0, 1'b0, 3'b010, 32'h28, 32'h0, 32'h33333333, 1'b0});
        run_txn('{1'b1, 1'b0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h11111111, 1'b0});

        // Reset in the middle of a store's ACCESS cycle
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h12345678);
        @(negedge clk);
        check("abort_gnt", 32'(m0Gnt), 32'd1);
        check("abort_we_before", 32'(memWriteEnable), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_we_now", 32'(memWriteEnable), 32'd0);
        check("abort_gnt_cleared", 32'(m0Gnt), 32'd0);
        check("abort_rdata", m0RData | m1RData, 32'h0);
        check("abort_mem_addr", memAddr, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("abort_no_write", mem_word(8'h30), 32'h0);
        check("abort_no_ack", {30'h0, m1Ack, m0Ack}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle_no_ack", {30'h0, m1Ack, m0Ack}, 32'h0);
        run_txn('{1'b0, 1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 32'h00000000, 1'b0});

        check("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
